sdram_arbiter: RTL

- Clock-domain-local front end that sits directly upstream of the SDRAM controller in the 72 MHz SDRAM clock domain.
- Arbitrates two request ports: port 0 (chipset/DMA) and port 1 (CPU).
- Schedules periodic auto-refresh.
- Generates the controller's cs/refresh/we/ds/addr/din strobe pattern with fixed cycle timing.
- Captures the controller's dout at a fixed latency and returns it to the requesting port with a one-cycle ack.

---
 rtl/sdram_arbiter_if.sv | 34 +++
 rtl/sdram_arbiter.sv | 123 ++++++++++++
 2 files changed

// File: rtl/sdram_arbiter_if.sv
// Port-side and controller-side signal bundle for the SDRAM front-end arbiter.
// slave = arbiter view, master = requesters/controller view.
interface sdram_arbiter_if;
  logic        p0_req, p0_we, p0_ack;
  logic [21:0] p0_addr;
  logic [1:0]  p0_ds;
  logic [15:0] p0_din, p0_dout;
  logic        p1_req, p1_we, p1_ack;
  logic [21:0] p1_addr;
  logic [1:0]  p1_ds;
  logic [15:0] p1_din, p1_dout;
  logic        ctl_ready, ctl_cs, ctl_refresh, ctl_we;
  logic [21:0] ctl_addr;
  logic [1:0]  ctl_ds;
  logic [15:0] ctl_din, ctl_dout;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_ds, p0_din,
    output p0_ack, p0_dout,
    input  p1_req, p1_we, p1_addr, p1_ds, p1_din,
    output p1_ack, p1_dout,
    input  ctl_ready, ctl_dout,
    output ctl_cs, ctl_refresh, ctl_we, ctl_addr, ctl_ds, ctl_din
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_ds, p0_din,
    input  p0_ack, p0_dout,
    output p1_req, p1_we, p1_addr, p1_ds, p1_din,
    input  p1_ack, p1_dout,
    output ctl_ready, ctl_dout,
    input  ctl_cs, ctl_refresh, ctl_we, ctl_addr, ctl_ds, ctl_din
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Two-port round-robin SDRAM front end with periodic refresh and fixed-timing
// slots: cs pulse, constant command fields, data capture at a fixed latency.
module sdram_arbiter #(
  parameter int CYCLE_LEN        = 10,
  parameter int CS_HIGH          = 3,
  parameter int LATENCY          = 8,
  parameter int REFRESH_INTERVAL = 560
) (
  input logic            clk,
  input logic            reset_n,
  sdram_arbiter_if.slave bus
);
  localparam int CW = $clog2(CYCLE_LEN + 1);
  localparam int RW = $clog2(REFRESH_INTERVAL);
  localparam logic [CW-1:0] CS_END   = CW'(CS_HIGH);
  localparam logic [CW-1:0] ACK_AT   = CW'(LATENCY - 1);
  localparam logic [CW-1:0] SLOT_END = CW'(CYCLE_LEN - 1);
  localparam logic [RW-1:0] REF_END  = RW'(REFRESH_INTERVAL - 1);

  typedef enum logic [1:0] {WAIT_READY, IDLE, SLOT} state_t;

  state_t          state;
  logic [CW-1:0]   slot_cnt;
  logic [RW-1:0]   ref_cnt;
  logic            ref_pending, last_grant, slot_port, slot_ref;
  logic [1:0]      req, we, ack;
  logic [1:0][21:0] addr;
  logic [1:0][1:0]  ds;
  logic [1:0][15:0] din, dout;
  logic            cs_q, refresh_q, we_q;
  logic [21:0]     addr_q;
  logic [1:0]      ds_q;
  logic [15:0]     din_q;
  logic            can_grant, ref_wrap, grant_ref, grant_port, winner;

  assign req  = {bus.p1_req, bus.p0_req};
  assign we   = {bus.p1_we, bus.p0_we};
  assign addr = {bus.p1_addr, bus.p0_addr};
  assign ds   = {bus.p1_ds, bus.p0_ds};
  assign din  = {bus.p1_din, bus.p0_din};

  assign bus.p0_ack      = ack[0];
  assign bus.p1_ack      = ack[1];
  assign bus.p0_dout     = dout[0];
  assign bus.p1_dout     = dout[1];
  assign bus.ctl_cs      = cs_q;
  assign bus.ctl_refresh = refresh_q;
  assign bus.ctl_we      = we_q;
  assign bus.ctl_addr    = addr_q;
  assign bus.ctl_ds      = ds_q;
  assign bus.ctl_din     = din_q;

  // The last slot cycle doubles as an idle cycle so slots can run back to back.
  always_comb begin
    can_grant  = (state == IDLE) || ((state == SLOT) && (slot_cnt == SLOT_END));
    ref_wrap   = (state != WAIT_READY) && (ref_cnt == REF_END);
    grant_ref  = can_grant && ref_pending;
    grant_port = can_grant && !ref_pending && (req != 2'b00);
    winner     = (req == 2'b11) ? ~last_grant : req[1];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= WAIT_READY;
      slot_cnt    <= '0;
      ref_cnt     <= '0;
      ref_pending <= 1'b0;
      last_grant  <= 1'b1;
      slot_port   <= 1'b0;
      slot_ref    <= 1'b0;
      ack         <= '0;
      dout        <= '0;
      cs_q        <= 1'b0;
      refresh_q   <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      ds_q        <= 2'b11;
      din_q       <= '0;
    end else begin
      ack <= '0;
      if (state != WAIT_READY) ref_cnt <= ref_wrap ? '0 : ref_cnt + 1'b1;
      // A wrap landing on the refresh grant re-arms pending, so none is lost.
      ref_pending <= ref_wrap | (ref_pending & ~grant_ref);
      if (state == WAIT_READY) begin
        if (bus.ctl_ready) state <= IDLE;
      end else begin
        if (state == SLOT) begin
          slot_cnt <= slot_cnt + 1'b1;
          cs_q     <= (slot_cnt + 1'b1) < CS_END;
          if ((slot_cnt == ACK_AT) && !slot_ref) begin
            ack[slot_port] <= 1'b1;
            if (!we_q) dout[slot_port] <= bus.ctl_dout;
          end
        end
        if (grant_ref || grant_port) begin
          state     <= SLOT;
          slot_cnt  <= '0;
          cs_q      <= 1'b1;
          slot_ref  <= grant_ref;
          refresh_q <= grant_ref;
          if (grant_ref) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            ds_q   <= 2'b11;
            din_q  <= '0;
          end else begin
            we_q       <= we[winner];
            addr_q     <= addr[winner];
            ds_q       <= ds[winner];
            din_q      <= din[winner];
            slot_port  <= winner;
            last_grant <= winner;
          end
        end else if (can_grant) begin
          state     <= IDLE;
          slot_cnt  <= '0;
          cs_q      <= 1'b0;
          refresh_q <= 1'b0;
        end
      end
    end
  end
endmodule
